program_counter: RTL and testbench

- Synchronous WIDTH-bit program counter for the 8-bit microprocessor datapath.
- Holds the address of the next instruction and increments by one when enabled.
- Parallel-loads a branch/jump target from the datapath.
- Output drives the instruction-memory address bus.

---
 rtl/pc_pkg.sv | 10 +
 rtl/program_counter.sv | 62 ++++++
 tb/tb_program_counter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared constants and the address type for the program counter.
package pc_pkg;

  localparam int PC_WIDTH = 8;

  typedef logic [PC_WIDTH-1:0] pc_addr_t;

  localparam pc_addr_t PC_RESET_VALUE = '0;

endpackage : pc_pkg

// File: rtl/program_counter.sv
// Program counter for the 8-bit datapath: parallel load, increment and hold.
// Define PC_WRAP_FLAG_EN to add a registered one-cycle wrap flag on FF->00 increments.
module program_counter
  import pc_pkg::*;
#(
  parameter int               WIDTH       = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic             pc_enable,
  input  logic [WIDTH-1:0] inp,
  output logic [WIDTH-1:0] out
`ifdef PC_WRAP_FLAG_EN
  ,
  output logic             wrap
`endif
);

  logic [WIDTH-1:0] pc_d, pc_q;

  // Load has priority over increment; neither means hold.
  always_comb begin
    // NOTE: default assigned first so every path drives pc_d and no latch is inferred.
    pc_d = pc_q;
    if (ld) begin
      pc_d = inp;
    end else if (pc_enable) begin
      pc_d = pc_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignment for registered state avoids simulation races.
    if (!reset) begin
      pc_q <= RESET_VALUE;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign out = pc_q;

`ifdef PC_WRAP_FLAG_EN
  logic wrap_d, wrap_q;

  // Only a true increment out of all-ones counts; a load of zero does not.
  assign wrap_d = !ld && pc_enable && (pc_q == '1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;
`endif

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter; the wrap flag is also checked when PC_WRAP_FLAG_EN is defined.
module tb_program_counter;
  import pc_pkg::*;

  typedef struct {
    logic [7:0] pc;
    logic       wrap;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       ld;
  logic       pc_enable;
  logic [7:0] inp;
  logic [7:0] out;
`ifdef PC_WRAP_FLAG_EN
  logic       wrap;
`endif

  int vectors_applied = 0;
  int miscompares     = 0;

  exp_t       sb[$];
  logic [7:0] model_pc;

  program_counter dut (
    .clk       (clk),
    .reset     (reset),
    .ld        (ld),
    .pc_enable (pc_enable),
    .inp       (inp),
    .out       (out)
`ifdef PC_WRAP_FLAG_EN
    ,
    .wrap      (wrap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors_applied++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_wrap(input string tag, input logic exp_wrap);
`ifdef PC_WRAP_FLAG_EN
    check(tag, 32'(wrap), 32'(exp_wrap));
`endif
  endtask

  // Drive one edge's worth of inputs, push the model's prediction, compare after the edge.
  task automatic step(input string tag, input logic l, input logic e, input logic [7:0] d);
    exp_t x;
    @(negedge clk);
    ld = l; pc_enable = e; inp = d;
    x.wrap = !l && e && (model_pc == 8'hFF);
    if (l)      model_pc = d;
    else if (e) model_pc = model_pc + 8'd1;
    x.pc = model_pc;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check(tag, 32'(out), 32'(x.pc));
      check_wrap({tag, "_wrap"}, x.wrap);
    end
  endtask

  initial begin
    reset = 1'b0; ld = 1'b0; pc_enable = 1'b0; inp = 8'h00;
    model_pc = 8'h00;

    // Reset must act before any clock edge.
    #3;
    check("reset_async", 32'(out), 32'h00);
    check_wrap("reset_wrap", 1'b0);

    @(negedge clk);
    reset = 1'b1;
    step("idle", 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 5; i++) step("inc", 1'b0, 1'b1, 8'h00);

    step("load18", 1'b1, 1'b0, 8'h18);
    for (int i = 0; i < 3; i++) step("inc_after_load", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 2; i++) step("hold", 1'b0, 1'b0, 8'h55);

    // Asynchronous reset dropped between edges with an increment pending.
    @(negedge clk);
    pc_enable = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("midrun_reset", 32'(out), 32'h00);
    @(posedge clk);
    #1;
    check("reset_held", 32'(out), 32'h00);
    check_wrap("reset_held_wrap", 1'b0);
    @(negedge clk);
    reset = 1'b1; pc_enable = 1'b0;
    model_pc = 8'h00;

    step("load_priority", 1'b1, 1'b1, 8'h40);

    step("loadFE", 1'b1, 1'b0, 8'hFE);
    step("incFF", 1'b0, 1'b1, 8'h00);
    step("wrap00", 1'b0, 1'b1, 8'h00);
    step("post_wrap", 1'b0, 1'b0, 8'h00);

    step("loadFF", 1'b1, 1'b0, 8'hFF);
    step("load00_nowrap", 1'b1, 1'b1, 8'h00);
    step("load_same", 1'b1, 1'b0, 8'h00);
    step("loadFF2", 1'b1, 1'b0, 8'hFF);
    step("holdFF", 1'b0, 1'b0, 8'h00);
    step("wrap_again", 1'b0, 1'b1, 8'h12);

    for (int i = 0; i < 60; i++) begin
      step("random", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule : tb_program_counter
